// File: rtl/slow_clk_ctrl.sv
// Divides clk by a runtime ratio N into a registered slow clock with rise/fall strobes.
// Latency: enable seen in STOP gives slow_clk high on the next edge; ratio changes land at a period boundary.
// Backpressure: cfg_ready drops while an accepted ratio waits for the boundary (DRAIN).
module slow_clk_ctrl #(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             slow_clk,
    output logic             slow_rise,
    output logic             slow_fall,
    output logic [CNT_W-1:0] cur_div,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEF_DIV);

    state_t           state;
    logic [CNT_W-1:0] pend_div;
    logic [CNT_W-1:0] cnt;

    logic             cfg_acc;
    logic [CNT_W-1:0] cfg_clamped;
    logic [CNT_W-1:0] start_div;
    logic [CNT_W-1:0] bound_div;

    // High phase is the shorter half, so odd ratios spend the extra cycle low.
    function automatic logic [CNT_W-1:0] hi_len(input logic [CNT_W-1:0] n);
        return n >> 1;
    endfunction

    function automatic logic [CNT_W-1:0] lo_len(input logic [CNT_W-1:0] n);
        return n - (n >> 1);
    endfunction

    assign cfg_ready   = (state != ST_DRAIN);
    assign busy        = (state != ST_STOP);
    assign cfg_acc     = cfg_valid && cfg_ready;
    assign cfg_clamped = (cfg_div < TWO) ? TWO : cfg_div;
    // Starting from STOP, a ratio accepted in the same cycle is used straight away.
    assign start_div   = cfg_acc ? cfg_clamped : cur_div;
    // At a boundary the next period takes the pending ratio if one is waiting.
    assign bound_div   = (state == ST_DRAIN) ? pend_div : cur_div;

    // Control FSM, phase counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_STOP;
            slow_clk  <= 1'b0;
            slow_rise <= 1'b0;
            slow_fall <= 1'b0;
            cur_div   <= RST_DIV;
            pend_div  <= '0;
            cnt       <= '0;
        end else begin
            slow_rise <= 1'b0;
            slow_fall <= 1'b0;
            case (state)
                ST_STOP: begin
                    if (cfg_acc) begin
                        cur_div <= cfg_clamped;
                    end
                    if (enable) begin
                        slow_clk  <= 1'b1;
                        slow_rise <= 1'b1;
                        cnt       <= hi_len(start_div) - ONE;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    if (slow_clk || cnt != '0) begin
                        // Inside a period: count down, switch to low phase when high expires.
                        if (slow_clk && cnt == '0) begin
                            slow_clk  <= 1'b0;
                            slow_fall <= 1'b1;
                            cnt       <= lo_len(cur_div) - ONE;
                        end else begin
                            cnt <= cnt - ONE;
                        end
                        if (cfg_acc) begin
                            pend_div <= cfg_clamped;
                            state    <= ST_DRAIN;
                        end
                    end else begin
                        // Period boundary: commit any pending ratio, then restart or stop.
                        if (state == ST_DRAIN) begin
                            cur_div <= pend_div;
                        end
                        if (enable) begin
                            slow_clk  <= 1'b1;
                            slow_rise <= 1'b1;
                            cnt       <= hi_len(bound_div) - ONE;
                            if (cfg_acc) begin
                                // Arrived with the boundary: it waits for the next one.
                                pend_div <= cfg_clamped;
                                state    <= ST_DRAIN;
                            end else begin
                                state    <= ST_RUN;
                            end
                        end else begin
                            // Stopping: nothing left to drain, so apply an update directly.
                            if (cfg_acc) begin
                                cur_div <= cfg_clamped;
                            end
                            cnt   <= '0;
                            state <= ST_STOP;
                        end
                    end
                end
                default: begin
                    slow_clk <= 1'b0;
                    cnt      <= '0;
                    state    <= ST_STOP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slow_clk_ctrl.sv
// Directed vector bench for slow_clk_ctrl (CNT_W=8, DEF_DIV=4).
// Each vector drives inputs on the falling edge and checks outputs 1ns after the rising edge.
// Expected values are hand-derived from the ratio/phase rules.
module tb_slow_clk_ctrl;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       slow_clk;
    logic       slow_rise;
    logic       slow_fall;
    logic [7:0] cur_div;
    logic       busy;

    slow_clk_ctrl #(.CNT_W(8), .DEF_DIV(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .slow_clk  (slow_clk),
        .slow_rise (slow_rise),
        .slow_fall (slow_fall),
        .cur_div   (cur_div),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       cv;
        logic [7:0] cd;
        logic       e_clk;
        logic       e_rise;
        logic       e_fall;
        logic [7:0] e_cur;
        logic       e_busy;
        logic       e_rdy;
    } vec_t;

    vec_t tbl[$];
    int   n_vec;
    int   n_bad;

    function automatic vec_t mk(input logic rst, input logic en, input logic cv, input logic [7:0] cd,
                                input logic c, input logic r, input logic f, input logic [7:0] cur,
                                input logic b, input logic rdy);
        vec_t v;
        v.rst = rst; v.en = en; v.cv = cv; v.cd = cd;
        v.e_clk = c; v.e_rise = r; v.e_fall = f; v.e_cur = cur; v.e_busy = b; v.e_rdy = rdy;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        reset     = v.rst;
        enable    = v.en;
        cfg_valid = v.cv;
        cfg_div   = v.cd;
        @(posedge clk);
        #1;
        n_vec++;
        if ({slow_clk, slow_rise, slow_fall, cur_div, busy, cfg_ready} !==
            {v.e_clk, v.e_rise, v.e_fall, v.e_cur, v.e_busy, v.e_rdy}) begin
            n_bad++;
            $display("FAIL %s: got clk=%b rise=%b fall=%b cur=%0d busy=%b rdy=%b, want clk=%b rise=%b fall=%b cur=%0d busy=%b rdy=%b",
                     name, slow_clk, slow_rise, slow_fall, cur_div, busy, cfg_ready,
                     v.e_clk, v.e_rise, v.e_fall, v.e_cur, v.e_busy, v.e_rdy);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        reset     = 1'b1;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = 8'd0;

        //                 rst en cv cd     clk ri fa cur busy rdy
        // Default ratio 4: 1,1,0,0 repeating, rise on first edge after release
        tbl.push_back(mk(1, 0, 0, 8'd0,   0, 0, 0, 8'd4, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'd0,   1, 1, 0, 8'd4, 1, 1));
        tbl.push_back(mk(0, 1, 0, 8'd0,   1, 0, 0, 8'd4, 1, 1));
        tbl.push_back(mk(0, 1, 0, 8'd0,   0, 0, 1, 8'd4, 1, 1));
        tbl.push_back(mk(0, 1, 0, 8'd0,   0, 0, 0, 8'd4, 1, 1));
        tbl.push_back(mk(0, 1, 0, 8'd0,   1, 1, 0, 8'd4, 1, 1));
        // Offer 7 mid-high: DRAIN, old period finishes, then 3 high / 4 low
        tbl.push_back(mk(0, 1, 1, 8'd7,   1, 0, 0, 8'd4, 1, 0));
        tbl.push_back(mk(0, 1, 0, 8'd0,   0, 0, 1, 8'd4, 1, 0));
        tbl.push_back(mk(0, 1, 0, 8'd0,   0, 0, 0, 8'd4, 1, 0));
        tbl.push_back(mk(0, 1, 0, 8'd0,   1, 1, 0, 8'd7, 1, 1));
        tbl.push_back(mk(0, 1, 0, 8'd0,   1, 0, 0, 8'd7, 1, 1));
        tbl.push_back(mk(0, 1, 0, 8'd0,   1, 0, 0, 8'd7, 1, 1));
        tbl.push_back(mk(0, 1, 0, 8'd0,   0, 0, 1, 8'd7, 1, 1));
        tbl.push_back(mk(0, 1, 0, 8'd0,   0, 0, 0, 8'd7, 1, 1));
        tbl.push_back(mk(0, 1, 0, 8'd0,   0, 0, 0, 8'd7, 1, 1));
        tbl.push_back(mk(0, 1, 0, 8'd0,   0, 0, 0, 8'd7, 1, 1));
        tbl.push_back(mk(0, 1, 0, 8'd0,   1, 1, 0, 8'd7, 1, 1));
        // Ratio 0 clamps to 2; toggles every cycle
        tbl.push_back(mk(1, 0, 0, 8'd0,   0, 0, 0, 8'd4, 0, 1));
        tbl.push_back(mk(0, 0, 1, 8'd0,   0, 0, 0, 8'd2, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'd0,   1, 1, 0, 8'd2, 1, 1));
        tbl.push_back(mk(0, 1, 0, 8'd0,   0, 0, 1, 8'd2, 1, 1));
        tbl.push_back(mk(0, 1, 0, 8'd0,   1, 1, 0, 8'd2, 1, 1));
        tbl.push_back(mk(0, 1, 0, 8'd0,   0, 0, 1, 8'd2, 1, 1));
        // Ratio 6, enable dropped after the rise: 2 more high + 3 low, then STOP
        tbl.push_back(mk(1, 0, 0, 8'd0,   0, 0, 0, 8'd4, 0, 1));
        tbl.push_back(mk(0, 0, 1, 8'd6,   0, 0, 0, 8'd6, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'd0,   1, 1, 0, 8'd6, 1, 1));
        tbl.push_back(mk(0, 0, 0, 8'd0,   1, 0, 0, 8'd6, 1, 1));
        tbl.push_back(mk(0, 0, 0, 8'd0,   1, 0, 0, 8'd6, 1, 1));
        tbl.push_back(mk(0, 0, 0, 8'd0,   0, 0, 1, 8'd6, 1, 1));
        tbl.push_back(mk(0, 0, 0, 8'd0,   0, 0, 0, 8'd6, 1, 1));
        tbl.push_back(mk(0, 0, 0, 8'd0,   0, 0, 0, 8'd6, 1, 1));
        tbl.push_back(mk(0, 0, 0, 8'd0,   0, 0, 0, 8'd6, 0, 1));
        tbl.push_back(mk(0, 0, 0, 8'd0,   0, 0, 0, 8'd6, 0, 1));
        // Ratio 5, update to 3 with enable low: 2H/3L completes, STOP, then 1H/2L
        tbl.push_back(mk(0, 0, 1, 8'd5,   0, 0, 0, 8'd5, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'd0,   1, 1, 0, 8'd5, 1, 1));
        tbl.push_back(mk(0, 0, 1, 8'd3,   1, 0, 0, 8'd5, 1, 0));
        tbl.push_back(mk(0, 0, 0, 8'd0,   0, 0, 1, 8'd5, 1, 0));
        tbl.push_back(mk(0, 0, 0, 8'd0,   0, 0, 0, 8'd5, 1, 0));
        tbl.push_back(mk(0, 0, 0, 8'd0,   0, 0, 0, 8'd5, 1, 0));
        tbl.push_back(mk(0, 0, 0, 8'd0,   0, 0, 0, 8'd3, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'd0,   1, 1, 0, 8'd3, 1, 1));
        tbl.push_back(mk(0, 1, 0, 8'd0,   0, 0, 1, 8'd3, 1, 1));
        tbl.push_back(mk(0, 1, 0, 8'd0,   0, 0, 0, 8'd3, 1, 1));
        tbl.push_back(mk(0, 1, 0, 8'd0,   1, 1, 0, 8'd3, 1, 1));
        // Update on the boundary waits a full period; held request during DRAIN ignored
        tbl.push_back(mk(0, 1, 0, 8'd0,   0, 0, 1, 8'd3, 1, 1));
        tbl.push_back(mk(0, 1, 0, 8'd0,   0, 0, 0, 8'd3, 1, 1));
        tbl.push_back(mk(0, 1, 1, 8'd2,   1, 1, 0, 8'd3, 1, 0));
        tbl.push_back(mk(0, 1, 1, 8'd9,   0, 0, 1, 8'd3, 1, 0));
        tbl.push_back(mk(0, 1, 1, 8'd9,   0, 0, 0, 8'd3, 1, 0));
        tbl.push_back(mk(0, 1, 0, 8'd0,   1, 1, 0, 8'd2, 1, 1));
        tbl.push_back(mk(0, 1, 0, 8'd0,   0, 0, 1, 8'd2, 1, 1));

        foreach (tbl[i]) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset while draining mid-low-phase: pending 9 must never show up
        apply(mk(1, 0, 0, 8'd0,   0, 0, 0, 8'd4, 0, 1), "drain_rst_pre");
        apply(mk(0, 0, 1, 8'd6,   0, 0, 0, 8'd6, 0, 1), "drain_cfg6");
        apply(mk(0, 1, 0, 8'd0,   1, 1, 0, 8'd6, 1, 1), "drain_rise");
        apply(mk(0, 1, 1, 8'd9,   1, 0, 0, 8'd6, 1, 0), "drain_accept9");
        apply(mk(0, 1, 0, 8'd0,   1, 0, 0, 8'd6, 1, 0), "drain_high");
        apply(mk(0, 1, 0, 8'd0,   0, 0, 1, 8'd6, 1, 0), "drain_fall");
        apply(mk(0, 1, 0, 8'd0,   0, 0, 0, 8'd6, 1, 0), "drain_midlow");
        apply(mk(1, 1, 0, 8'd0,   0, 0, 0, 8'd4, 0, 1), "drain_reset");
        apply(mk(0, 1, 0, 8'd0,   1, 1, 0, 8'd4, 1, 1), "post_rst_rise");
        apply(mk(0, 1, 0, 8'd0,   1, 0, 0, 8'd4, 1, 1), "post_rst_high");
        apply(mk(0, 1, 0, 8'd0,   0, 0, 1, 8'd4, 1, 1), "post_rst_fall");
        apply(mk(0, 1, 0, 8'd0,   0, 0, 0, 8'd4, 1, 1), "post_rst_low");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
